// File: rtl/alu_arb_pkg.sv
// rtl/alu_arb_pkg.sv - shared ALU opcode type and arbiter constants
//
// Purpose: types and constants shared by the ALU, its arbiter and the
// requesters that drive it.
// Contents:
//   alu_op_t              ALU opcode; value 0 (ALU_ADD) is the reset opcode
//   ALU_OP_W              width of one packed opcode field
//   ALU_ARB_LOCK_TIMEOUT  idle cycles after which an unused lock is dropped
//   ALU_ARB_TMO_W         width of the lock timeout counter
//   onehot_of()           index -> one-hot helper for grant/response vectors

package alu_arb_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } alu_op_t;

    localparam int ALU_OP_W             = $bits(alu_op_t);
    localparam int ALU_ARB_LOCK_TIMEOUT = 16;
    localparam int ALU_ARB_TMO_W        = $clog2(ALU_ARB_LOCK_TIMEOUT);

    // Returns a 32-bit one-hot word; callers truncate to their own width.
    function automatic logic [31:0] onehot_of(input int unsigned idx);
        logic [31:0] v;
        v = '0;
        v[idx[4:0]] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/alu_arb_rr_pick.sv
// rtl/alu_arb_rr_pick.sv - combinational round-robin picker
//
// Purpose: picks the first eligible requester scanning upward from ptr+1,
// wrapping around. A requester is eligible when both req and mask are set.
// Written generically so it can also serve other shared-port arbiters.
// Ports:
//   req   in   N      request vector
//   ptr   in   ID_W   index of the last winner
//   mask  in   N      eligibility mask (all ones for plain round-robin)
//   gnt   out  N      one-hot grant, zero when nothing is eligible
//   idx   out  ID_W   index of the granted requester (0 when gnt is zero)

module alu_arb_rr_pick #(
    parameter int N    = 2,
    parameter int ID_W = $clog2(N)
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] ptr,
    input  logic [N-1:0]    mask,
    output logic [N-1:0]    gnt,
    output logic [ID_W-1:0] idx
);

    logic            found;
    logic [ID_W-1:0] cand;

    // Offsets 1..N cover every requester once, ending with ptr itself, so the
    // previous winner has lowest priority.
    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int k = 1; k <= N; k++) begin
            cand = ID_W'((int'(ptr) + k) % N);
            if (!found && req[cand] && mask[cand]) begin
                found     = 1'b1;
                gnt[cand] = 1'b1;
                idx       = cand;
            end
        end
    end

endmodule

// File: rtl/alu_arb.sv
// rtl/alu_arb.sv - round-robin ALU sharing arbiter with lock and 2-stage pipe
//
// Purpose: shares one combinational ALU among N_REQ requesters. A granted
// request is registered into the operand stage (driving the ALU), and the
// ALU result is registered one cycle later and returned to its owner.
// A requester may lock the ALU for multi-step sequences; an unused lock is
// dropped after ALU_ARB_LOCK_TIMEOUT idle cycles.
// Ports:
//   clk_i         in   1                 clock
//   reset_i       in   1                 synchronous active-high reset
//   req_i         in   N_REQ             request valid per requester
//   lock_i        in   N_REQ             lock request, sampled with req_i
//   op_a_i        in   N_REQ*WORD_LEN    packed operand A per requester
//   op_b_i        in   N_REQ*WORD_LEN    packed operand B per requester
//   opc_i         in   N_REQ*ALU_OP_W    packed opcode per requester
//   gnt_o         out  N_REQ             one-hot combinational grant
//   rsp_valid_o   out  N_REQ             one-hot registered response valid
//   rsp_data_o    out  WORD_LEN          registered result (shared)
//   alu_op_a_o    out  WORD_LEN          ALU operand A
//   alu_op_b_o    out  WORD_LEN          ALU operand B
//   alu_opc_o     out  alu_op_t          ALU opcode
//   alu_op_res_i  in   WORD_LEN          ALU combinational result
//   busy_o        out  1                 any pipeline stage valid

module alu_arb
    import alu_arb_pkg::*;
#(
    parameter int WORD_LEN = 64,
    parameter int N_REQ    = 2
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    input  logic [N_REQ-1:0]            req_i,
    input  logic [N_REQ-1:0]            lock_i,
    input  logic [N_REQ*WORD_LEN-1:0]   op_a_i,
    input  logic [N_REQ*WORD_LEN-1:0]   op_b_i,
    input  logic [N_REQ*ALU_OP_W-1:0]   opc_i,
    output logic [N_REQ-1:0]            gnt_o,
    output logic [N_REQ-1:0]            rsp_valid_o,
    output logic [WORD_LEN-1:0]         rsp_data_o,
    output logic [WORD_LEN-1:0]         alu_op_a_o,
    output logic [WORD_LEN-1:0]         alu_op_b_o,
    output alu_op_t                     alu_opc_o,
    input  logic [WORD_LEN-1:0]         alu_op_res_i,
    output logic                        busy_o
);

    localparam int ID_W = $clog2(N_REQ);
    localparam logic [ALU_ARB_TMO_W-1:0] TMO_LAST = ALU_ARB_TMO_W'(ALU_ARB_LOCK_TIMEOUT - 1);

    // Arbitration state
    logic [ID_W-1:0]          rr_ptr;
    logic                     lock_vld;
    logic [ID_W-1:0]          lock_id;
    logic [ALU_ARB_TMO_W-1:0] lock_tmo;

    // Operand stage bookkeeping
    logic                     s1_vld;
    logic [ID_W-1:0]          s1_id;

    // Picker interface
    logic [N_REQ-1:0]         pick_mask;
    logic [N_REQ-1:0]         pick_gnt;
    logic [ID_W-1:0]          win_idx;
    logic                     accept;

    // Per-requester views of the packed operand buses
    logic [WORD_LEN-1:0]      op_a_arr [N_REQ];
    logic [WORD_LEN-1:0]      op_b_arr [N_REQ];
    alu_op_t                  opc_arr  [N_REQ];

    for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
        assign op_a_arr[g] = op_a_i[g*WORD_LEN +: WORD_LEN];
        assign op_b_arr[g] = op_b_i[g*WORD_LEN +: WORD_LEN];
        assign opc_arr[g]  = alu_op_t'(opc_i[g*ALU_OP_W +: ALU_OP_W]);
    end

    // A held lock narrows eligibility to the owner; the picker still runs
    // from rr_ptr so the owner is found wherever it sits.
    always_comb begin
        pick_mask = '1;
        if (lock_vld) begin
            pick_mask = N_REQ'(onehot_of(int'(lock_id)));
        end
    end

    alu_arb_rr_pick #(
        .N    (N_REQ),
        .ID_W (ID_W)
    ) u_pick (
        .req  (req_i),
        .ptr  (rr_ptr),
        .mask (pick_mask),
        .gnt  (pick_gnt),
        .idx  (win_idx)
    );

    assign gnt_o  = reset_i ? '0 : pick_gnt;
    assign accept = |gnt_o;

    // Round-robin pointer, lock ownership and lock timeout.
    // While locked, an accept can only be the owner's, so any accept either
    // renews the lock or releases it and always clears the idle counter.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rr_ptr   <= ID_W'(N_REQ - 1);
            lock_vld <= 1'b0;
            lock_id  <= '0;
            lock_tmo <= '0;
        end else begin
            if (accept) begin
                rr_ptr   <= win_idx;
                lock_tmo <= '0;
                if (lock_i[win_idx]) begin
                    lock_vld <= 1'b1;
                    lock_id  <= win_idx;
                end else begin
                    lock_vld <= 1'b0;
                end
            end else if (lock_vld && !req_i[lock_id]) begin
                if (lock_tmo == TMO_LAST) begin
                    lock_vld <= 1'b0;
                    lock_tmo <= '0;
                end else begin
                    lock_tmo <= lock_tmo + 1'b1;
                end
            end else begin
                lock_tmo <= '0;
            end
        end
    end

    // Stage 1: capture the winner's operands. The ALU inputs hold their last
    // value on idle cycles so the ALU sees no needless toggling.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            s1_vld     <= 1'b0;
            s1_id      <= '0;
            alu_op_a_o <= '0;
            alu_op_b_o <= '0;
            alu_opc_o  <= alu_op_t'(0);
        end else if (accept) begin
            s1_vld     <= 1'b1;
            s1_id      <= win_idx;
            alu_op_a_o <= op_a_arr[win_idx];
            alu_op_b_o <= op_b_arr[win_idx];
            alu_opc_o  <= opc_arr[win_idx];
        end else begin
            s1_vld     <= 1'b0;
        end
    end

    // Stage 2: register the ALU result and route the valid to its owner.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rsp_valid_o <= '0;
            rsp_data_o  <= '0;
        end else if (s1_vld) begin
            rsp_valid_o <= N_REQ'(onehot_of(int'(s1_id)));
            rsp_data_o  <= alu_op_res_i;
        end else begin
            rsp_valid_o <= '0;
        end
    end

    assign busy_o = s1_vld | (|rsp_valid_o);

endmodule

// File: tb/tb_alu_arb.sv
// tb/tb_alu_arb.sv - scoreboard bench for alu_arb

module tb_alu_arb;
    import alu_arb_pkg::*;

    localparam int W = 64;
    localparam int N = 2;

    logic               clk = 1'b0;
    logic               reset_i;
    logic [N-1:0]       req_i;
    logic [N-1:0]       lock_i;
    logic [N*W-1:0]     op_a_i;
    logic [N*W-1:0]     op_b_i;
    logic [N*ALU_OP_W-1:0] opc_i;
    logic [N-1:0]       gnt_o;
    logic [N-1:0]       rsp_valid_o;
    logic [W-1:0]       rsp_data_o;
    logic [W-1:0]       alu_op_a_o;
    logic [W-1:0]       alu_op_b_o;
    alu_op_t            alu_opc_o;
    logic [W-1:0]       alu_op_res_i;
    logic               busy_o;

    logic [W-1:0]       rq_a   [N];
    logic [W-1:0]       rq_b   [N];
    alu_op_t            rq_opc [N];

    typedef struct {
        logic [N-1:0] id;
        logic [W-1:0] data;
        int           cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   cyc   = 0;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign op_a_i = {rq_a[1], rq_a[0]};
    assign op_b_i = {rq_b[1], rq_b[0]};
    assign opc_i  = {rq_opc[1], rq_opc[0]};

    // Reference ALU sitting behind the arbiter.
    always_comb begin
        case (alu_opc_o)
            ALU_ADD: alu_op_res_i = alu_op_a_o + alu_op_b_o;
            ALU_SUB: alu_op_res_i = alu_op_a_o - alu_op_b_o;
            ALU_AND: alu_op_res_i = alu_op_a_o & alu_op_b_o;
            ALU_OR:  alu_op_res_i = alu_op_a_o | alu_op_b_o;
            ALU_XOR: alu_op_res_i = alu_op_a_o ^ alu_op_b_o;
            default: alu_op_res_i = '0;
        endcase
    end

    alu_arb #(.WORD_LEN(W), .N_REQ(N)) dut (
        .clk_i        (clk),
        .reset_i      (reset_i),
        .req_i        (req_i),
        .lock_i       (lock_i),
        .op_a_i       (op_a_i),
        .op_b_i       (op_b_i),
        .opc_i        (opc_i),
        .gnt_o        (gnt_o),
        .rsp_valid_o  (rsp_valid_o),
        .rsp_data_o   (rsp_data_o),
        .alu_op_a_o   (alu_op_a_o),
        .alu_op_b_o   (alu_op_b_o),
        .alu_opc_o    (alu_opc_o),
        .alu_op_res_i (alu_op_res_i),
        .busy_o       (busy_o)
    );

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic set_rq(input int i, input logic r, input logic l,
                          input logic [W-1:0] a, input logic [W-1:0] b, input alu_op_t o);
        req_i[i]  = r;
        lock_i[i] = l;
        rq_a[i]   = a;
        rq_b[i]   = b;
        rq_opc[i] = o;
    endtask

    task automatic clr_rq();
        req_i  = '0;
        lock_i = '0;
    endtask

    // One clock cycle: check the grant mid-cycle, log the expected response,
    // and return just after the next rising edge.
    task automatic step(input logic [N-1:0] exp_gnt, input logic [W-1:0] exp_data, input bit push);
        @(negedge clk);
        chk("gnt_o", W'(gnt_o), W'(exp_gnt));
        if (push && exp_gnt != '0) sb.push_back('{exp_gnt, exp_data, cyc + 2});
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_i = 1'b1;
        clr_rq();
        @(posedge clk);
        #1;
        reset_i = 1'b0;
    endtask

    always @(negedge clk) begin
        if (rsp_valid_o != '0) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_rsp: rsp_valid_o=%b data=0x%0h with no response due (cycle %0d)",
                         rsp_valid_o, rsp_data_o, cyc);
            end else begin
                mon_e = sb.pop_front();
                chk("rsp_valid_o", W'(rsp_valid_o), W'(mon_e.id));
                chk("rsp_data_o", rsp_data_o, mon_e.data);
                chk("rsp_cycle", W'(cyc), W'(mon_e.cyc));
            end
        end
    end

    initial begin
        for (int i = 0; i < N; i++) set_rq(i, 1'b0, 1'b0, '0, '0, ALU_ADD);

        // Reset state, with requests pending to show the grant is forced off
        reset_i = 1'b1;
        req_i   = 2'b11;
        @(negedge clk);
        chk("gnt_in_reset", W'(gnt_o), 0);
        @(posedge clk);
        #1;
        chk("rst_rsp_valid", W'(rsp_valid_o), 0);
        chk("rst_rsp_data", rsp_data_o, 0);
        chk("rst_busy", W'(busy_o), 0);
        chk("rst_alu_a", alu_op_a_o, 0);
        chk("rst_alu_opc", W'(alu_opc_o), 0);
        reset_i = 1'b0;
        clr_rq();

        // Single requester: 5 + 3
        set_rq(0, 1'b1, 1'b0, 64'd5, 64'd3, ALU_ADD);
        step(2'b01, 64'd8, 1'b1);
        chk("busy_s1", W'(busy_o), 1);
        clr_rq();
        step(2'b00, '0, 1'b0);
        chk("busy_s2", W'(busy_o), 1);
        chk("rsp_valid_s2", W'(rsp_valid_o), 1);
        step(2'b00, '0, 1'b0);
        chk("busy_idle", W'(busy_o), 0);

        // Fairness: both requesting for 4 cycles from a fresh pointer
        do_reset();
        set_rq(0, 1'b1, 1'b0, 64'd10, 64'd1, ALU_ADD);
        set_rq(1, 1'b1, 1'b0, 64'd20, 64'd2, ALU_SUB);
        step(2'b01, 64'd11, 1'b1);
        step(2'b10, 64'd18, 1'b1);
        step(2'b01, 64'd11, 1'b1);
        step(2'b10, 64'd18, 1'b1);
        clr_rq();
        step(2'b00, '0, 1'b0);
        step(2'b00, '0, 1'b0);

        // Lock: requester 1 holds the ALU until it drops lock_i
        set_rq(0, 1'b1, 1'b0, 64'hF0, 64'h3C, ALU_AND);
        set_rq(1, 1'b1, 1'b1, 64'hFF, 64'h0F, ALU_XOR);
        step(2'b01, 64'h30, 1'b1);
        step(2'b10, 64'hF0, 1'b1);
        step(2'b10, 64'hF0, 1'b1);
        step(2'b10, 64'hF0, 1'b1);
        lock_i[1] = 1'b0;
        step(2'b10, 64'hF0, 1'b1);
        step(2'b01, 64'h30, 1'b1);
        clr_rq();
        step(2'b00, '0, 1'b0);
        step(2'b00, '0, 1'b0);

        // Lock timeout: owner goes idle, requester 0 waits 16 cycles
        set_rq(1, 1'b1, 1'b1, 64'd7, 64'd7, ALU_ADD);
        step(2'b10, 64'd14, 1'b1);
        set_rq(1, 1'b0, 1'b0, 64'd7, 64'd7, ALU_ADD);
        set_rq(0, 1'b1, 1'b0, 64'h100, 64'h1, ALU_OR);
        for (int i = 0; i < ALU_ARB_LOCK_TIMEOUT; i++) step(2'b00, '0, 1'b0);
        step(2'b01, 64'h101, 1'b1);
        clr_rq();
        step(2'b00, '0, 1'b0);
        step(2'b00, '0, 1'b0);

        // Reset mid-flight: SUB 9-4 is dropped; pointer returns to requester 0
        set_rq(0, 1'b1, 1'b0, 64'd9, 64'd4, ALU_SUB);
        step(2'b01, 64'd5, 1'b0);
        reset_i = 1'b1;
        set_rq(0, 1'b0, 1'b0, 64'd9, 64'd4, ALU_SUB);
        set_rq(1, 1'b1, 1'b0, 64'd0, 64'd0, ALU_XOR);
        step(2'b00, '0, 1'b0);
        reset_i = 1'b0;
        chk("midrst_rsp_valid", W'(rsp_valid_o), 0);
        chk("midrst_rsp_data", rsp_data_o, 0);
        chk("midrst_busy", W'(busy_o), 0);

        // Back-to-back from requester 0: ADD 1+1 then SUB 10-3
        set_rq(0, 1'b1, 1'b0, 64'd1, 64'd1, ALU_ADD);
        step(2'b01, 64'd2, 1'b1);
        set_rq(0, 1'b1, 1'b0, 64'd10, 64'd3, ALU_SUB);
        set_rq(1, 1'b0, 1'b0, 64'd0, 64'd0, ALU_XOR);
        step(2'b01, 64'd7, 1'b1);
        clr_rq();
        step(2'b00, '0, 1'b0);
        step(2'b00, '0, 1'b0);
        step(2'b00, '0, 1'b0);

        chk("responses_outstanding", W'(sb.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
